data_cache: RTL and testbench
=============================

Name: data_cache

Overview:
- Direct-mapped, write-back, write-allocate data cache.
- Sits between the CPU's memory-access stage and main data memory.
- Responds to the READ/WRITE/BUSYWAIT handshake driven by the CPU control path.
- Acts as initiator on a block-wide (32-bit) main-memory interface.
- Hits complete with zero stall; misses stall the CPU through BUSYWAIT until refill (and any write-back) finishes.

Parameters:
- NUM_BLOCKS, 8, number of cache lines (power of 2).
- BLOCK_BYTES, 4, bytes per line (fixed by the 32-bit memory bus).
- ADDR_W, 8, CPU byte-address width.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- READ  in  1  CPU load request.
- WRITE  in  1  CPU store request.
- ADDRESS  in  8  CPU byte address: tag[7:5], index[4:2], offset[1:0].
- WRITEDATA  in  8  CPU store data.
- READDATA  out  8  CPU load data.
- BUSYWAIT  out  1  CPU stall.
- MEM_READ  out  1  main-memory block read request.
- MEM_WRITE  out  1  main-memory block write request.
- MEM_ADDRESS  out  6  block address {tag,index}.
- MEM_WRITEDATA  out  32  victim block.
- MEM_READDATA  in  32  refill block.
- MEM_BUSYWAIT  in  1  memory busy; operation done when low at a posedge while a request is held.

Behaviour:
- Reset (sync, CLK posedge with RESET=1):
  - All valid and dirty bits cleared; state=IDLE.
  - MEM_READ=0, MEM_WRITE=0, BUSYWAIT=0, READDATA=0.
  - Tag/data contents are don't-care.
- RESET mid-miss aborts the memory transaction immediately: MEM_* deasserted the cycle after the reset edge, no array update.
- Request = READ|WRITE. READ and WRITE together is treated as WRITE.
- Hit = valid[index] && tag[index]==ADDRESS[7:5]. Evaluated combinationally.
- BUSYWAIT = request && !(state==IDLE && hit). Combinational, so a hit never stalls.
- Read hit: READDATA = data[index][offset*8 +: 8] combinationally; no array change.
- Write hit: at the posedge, the byte is written and dirty[index]=1.
- States:
  - IDLE: on a request miss, go to WRITE_BACK if valid&&dirty, else MEM_READ.
  - WRITE_BACK:
    - Outputs: MEM_WRITE=1, MEM_ADDRESS={victim tag,index}, MEM_WRITEDATA=victim block.
    - When MEM_BUSYWAIT==0 at a posedge, go to MEM_READ.
  - MEM_READ:
    - Outputs: MEM_READ=1, MEM_ADDRESS=ADDRESS[7:2].
    - When MEM_BUSYWAIT==0 at a posedge, go to UPDATE.
  - UPDATE (1 cycle):
    - Write MEM_READDATA to line; tag updated; valid=1; dirty=0.
    - Go to IDLE. The access then hits, and BUSYWAIT falls combinationally in IDLE.
- MEM_READ/MEM_WRITE are registered state decodes, never asserted together, and held until the completion edge.
- The CPU holds ADDRESS/READ/WRITE/WRITEDATA stable while BUSYWAIT=1. A request dropped mid-miss still completes the refill.
- Miss penalty, clean line: 2 + memory-latency cycles. Dirty line adds one more memory transaction.
- Boundaries:
  - Index wrap: address 0xFF maps to index 7, offset 3.
  - Every tag mismatch on a valid line is a conflict miss; no other replacement policy.

Optional Feature:
- Macro: DATA_CACHE_STATS_EN.
- Defined:
  - Adds outputs HIT_COUNT[15:0] and MISS_COUNT[15:0].
  - HIT_COUNT increments on each IDLE-state hit that completes an access.
  - MISS_COUNT increments on each IDLE→miss transition.
  - Both saturate at 0xFFFF and clear on RESET.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package cache_pkg:
  - State enum {IDLE, WRITE_BACK, MEM_READ, UPDATE}.
  - Constants TAG_W=3, INDEX_W=3, OFFSET_W=2, BLOCK_W=32.
  - Address-field extract helpers.
- Sub-module cache_line_array: valid/dirty/tag/data storage with a byte-write port and a block-refill port.
- Controller FSM stays in data_cache.

Test Plan:
- Reset, then READ 0x04 (cold miss, mem latency 5, MEM_READDATA=0xDDCCBBAA) → MEM_READ with MEM_ADDRESS=0x01; after UPDATE, READDATA=0xAA and BUSYWAIT falls.
- WRITE 0x05 data 0x5A after the above → no stall, BUSYWAIT=0; subsequent READ 0x05 returns 0x5A.
- READ 0x24 (same index 1, tag 1) with line 1 dirty → MEM_WRITE to addr 0x01 with data 0xDDCC5AAA first, then MEM_READ addr 0x09.
- READ and WRITE both high to 0x10 data 0x77 → treated as write; READ 0x10 afterwards returns 0x77.
- RESET asserted during MEM_READ → MEM_READ=0 next cycle; READ 0x04 afterwards misses again (valid cleared).
- With DATA_CACHE_STATS_EN, 1 miss + 3 hits → MISS_COUNT=1, HIT_COUNT=3; 0x10000 hits → HIT_COUNT saturates at 0xFFFF.

Source files
------------

// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the data_cache slice:
//   - address field widths, block width and CPU address width
//   - controller state encoding
//   - split_addr(): breaks a CPU byte address into tag / index / offset
// -----------------------------------------------------------------------------
package cache_pkg;

  localparam int TAG_W      = 3;
  localparam int INDEX_W    = 3;
  localparam int OFFSET_W   = 2;
  localparam int BLOCK_W    = 32;
  localparam int CPU_ADDR_W = TAG_W + INDEX_W + OFFSET_W;

  // State names carry an S_ prefix so they cannot collide with the
  // MEM_READ port of the cache.
  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WRITE_BACK = 2'd1,
    S_MEM_READ   = 2'd2,
    S_UPDATE     = 2'd3
  } cache_state_e;

  typedef struct packed {
    logic [TAG_W-1:0]    tag;
    logic [INDEX_W-1:0]  index;
    logic [OFFSET_W-1:0] offset;
  } addr_fields_t;

  function automatic addr_fields_t split_addr(input logic [CPU_ADDR_W-1:0] addr);
    return addr_fields_t'(addr);
  endfunction

endpackage

// File: rtl/cache_line_array.sv
// -----------------------------------------------------------------------------
// cache_line_array
// Valid / dirty / tag / data storage for the direct-mapped cache.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset (clears valid+dirty)
//   rd_index_i              combinational lookup index
//   rd_valid_o/rd_dirty_o   status of the looked-up line
//   rd_tag_o/rd_block_o     tag and 32-bit block of the looked-up line
//   bw_*                    CPU byte-write port (sets dirty)
//   rf_*                    block refill port (sets valid, clears dirty, loads tag)
// -----------------------------------------------------------------------------
module cache_line_array
  import cache_pkg::*;
#(
  parameter int NUM_BLOCKS = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [INDEX_W-1:0]  rd_index_i,
  output logic                rd_valid_o,
  output logic                rd_dirty_o,
  output logic [TAG_W-1:0]    rd_tag_o,
  output logic [BLOCK_W-1:0]  rd_block_o,
  input  logic                bw_en_i,
  input  logic [INDEX_W-1:0]  bw_index_i,
  input  logic [OFFSET_W-1:0] bw_offset_i,
  input  logic [7:0]          bw_data_i,
  input  logic                rf_en_i,
  input  logic [INDEX_W-1:0]  rf_index_i,
  input  logic [TAG_W-1:0]    rf_tag_i,
  input  logic [BLOCK_W-1:0]  rf_block_i
);

  logic [NUM_BLOCKS-1:0] valid_q;
  logic [NUM_BLOCKS-1:0] dirty_q;
  logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
  logic [BLOCK_W-1:0]    data_q [NUM_BLOCKS];

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_dirty_o = dirty_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_block_o = data_q[rd_index_i];

  // Line status bits; the only state that reset has to clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (rf_en_i) begin
      valid_q[rf_index_i] <= 1'b1;
      dirty_q[rf_index_i] <= 1'b0;
    end else if (bw_en_i) begin
      dirty_q[bw_index_i] <= 1'b1;
    end
  end

  // Tag and data payload; contents are meaningless until the line is valid.
  // Refill and byte write never coincide (UPDATE vs IDLE).
  always_ff @(posedge clk_i) begin
    if (rf_en_i) begin
      tag_q[rf_index_i]  <= rf_tag_i;
      data_q[rf_index_i] <= rf_block_i;
    end else if (bw_en_i) begin
      data_q[bw_index_i][{bw_offset_i, 3'b000} +: 8] <= bw_data_i;
    end
  end

endmodule

// File: rtl/data_cache.sv
// -----------------------------------------------------------------------------
// data_cache
// Direct-mapped, write-back, write-allocate data cache between the CPU
// memory stage and a 32-bit block-wide main memory.
// Ports:
//   CLK, RESET                 clock, synchronous active-high reset
//   READ, WRITE                CPU request (both high is treated as a write)
//   ADDRESS, WRITEDATA         CPU byte address {tag,index,offset} and store data
//   READDATA, BUSYWAIT         CPU load data and stall (both combinational)
//   MEM_READ, MEM_WRITE        registered block read / write-back requests
//   MEM_ADDRESS, MEM_WRITEDATA block address {tag,index} and victim block
//   MEM_READDATA, MEM_BUSYWAIT refill block and memory busy
// Optional build macro DATA_CACHE_STATS_EN adds saturating HIT_COUNT and
// MISS_COUNT outputs.
// -----------------------------------------------------------------------------
module data_cache
  import cache_pkg::*;
#(
  parameter int NUM_BLOCKS  = 8,
  parameter int BLOCK_BYTES = 4,
  parameter int ADDR_W      = 8
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       READ,
  input  logic                       WRITE,
  input  logic [ADDR_W-1:0]          ADDRESS,
  input  logic [7:0]                 WRITEDATA,
  output logic [7:0]                 READDATA,
  output logic                       BUSYWAIT,
  output logic                       MEM_READ,
  output logic                       MEM_WRITE,
  output logic [ADDR_W-OFFSET_W-1:0] MEM_ADDRESS,
  output logic [BLOCK_BYTES*8-1:0]   MEM_WRITEDATA,
  input  logic [BLOCK_BYTES*8-1:0]   MEM_READDATA,
  input  logic                       MEM_BUSYWAIT
`ifdef DATA_CACHE_STATS_EN
  ,
  output logic [15:0]                HIT_COUNT,
  output logic [15:0]                MISS_COUNT
`endif
);

  cache_state_e          state_q;
  addr_fields_t          a_s;
  addr_fields_t          miss_q;       // address of the access being serviced
  logic [BLOCK_W-1:0]    fill_q;       // block captured on refill completion
  logic                  req_s;
  logic                  hit_s;
  logic                  idle_hit_s;
  logic                  line_valid_s;
  logic                  line_dirty_s;
  logic [TAG_W-1:0]      line_tag_s;
  logic [BLOCK_W-1:0]    line_block_s;

  assign a_s        = split_addr(ADDRESS);
  assign req_s      = READ | WRITE;
  assign hit_s      = line_valid_s && (line_tag_s == a_s.tag);
  assign idle_hit_s = (state_q == S_IDLE) && hit_s;
  assign BUSYWAIT   = req_s && !idle_hit_s;
  // Gated by hit so READDATA is zero whenever the line holds nothing useful.
  assign READDATA   = hit_s ? line_block_s[{a_s.offset, 3'b000} +: 8] : 8'h00;

  cache_line_array #(
    .NUM_BLOCKS (NUM_BLOCKS)
  ) u_lines (
    .clk_i       (CLK),
    .rst_i       (RESET),
    .rd_index_i  (a_s.index),
    .rd_valid_o  (line_valid_s),
    .rd_dirty_o  (line_dirty_s),
    .rd_tag_o    (line_tag_s),
    .rd_block_o  (line_block_s),
    .bw_en_i     (idle_hit_s && WRITE),
    .bw_index_i  (a_s.index),
    .bw_offset_i (a_s.offset),
    .bw_data_i   (WRITEDATA),
    .rf_en_i     (state_q == S_UPDATE),
    .rf_index_i  (miss_q.index),
    .rf_tag_i    (miss_q.tag),
    .rf_block_i  (fill_q)
  );

  // Miss controller: state plus registered memory-side outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= S_IDLE;
      MEM_READ      <= 1'b0;
      MEM_WRITE     <= 1'b0;
      MEM_ADDRESS   <= '0;
      MEM_WRITEDATA <= '0;
      miss_q        <= '0;
      fill_q        <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_s && !hit_s) begin
            // Latch the miss address so a request dropped mid-miss still
            // refills the right line.
            miss_q <= a_s;
            if (line_valid_s && line_dirty_s) begin
              state_q       <= S_WRITE_BACK;
              MEM_WRITE     <= 1'b1;
              MEM_ADDRESS   <= {line_tag_s, a_s.index};
              MEM_WRITEDATA <= line_block_s;
            end else begin
              state_q     <= S_MEM_READ;
              MEM_READ    <= 1'b1;
              MEM_ADDRESS <= {a_s.tag, a_s.index};
            end
          end
        end
        S_WRITE_BACK: begin
          if (!MEM_BUSYWAIT) begin
            state_q     <= S_MEM_READ;
            MEM_WRITE   <= 1'b0;
            MEM_READ    <= 1'b1;
            MEM_ADDRESS <= {miss_q.tag, miss_q.index};
          end
        end
        S_MEM_READ: begin
          if (!MEM_BUSYWAIT) begin
            state_q  <= S_UPDATE;
            MEM_READ <= 1'b0;
            fill_q   <= MEM_READDATA;
          end
        end
        S_UPDATE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q   <= S_IDLE;
          MEM_READ  <= 1'b0;
          MEM_WRITE <= 1'b0;
        end
      endcase
    end
  end

`ifdef DATA_CACHE_STATS_EN
  logic [15:0] hit_count_q;
  logic [15:0] miss_count_q;

  assign HIT_COUNT  = hit_count_q;
  assign MISS_COUNT = miss_count_q;

  // Saturating hit/miss counters; both observe only IDLE-state decisions.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      hit_count_q  <= 16'h0000;
      miss_count_q <= 16'h0000;
    end else begin
      if (idle_hit_s && req_s && (hit_count_q != 16'hFFFF)) begin
        hit_count_q <= hit_count_q + 16'd1;
      end
      if ((state_q == S_IDLE) && req_s && !hit_s && (miss_count_q != 16'hFFFF)) begin
        miss_count_q <= miss_count_q + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_data_cache.sv
module tb_data_cache;

  logic        CLK = 1'b0;
  logic        RESET, READ, WRITE;
  logic [7:0]  ADDRESS, WRITEDATA, READDATA;
  logic        BUSYWAIT, MEM_READ, MEM_WRITE, MEM_BUSYWAIT;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA, MEM_READDATA;
`ifdef DATA_CACHE_STATS_EN
  logic [15:0] HIT_COUNT, MISS_COUNT;
`endif

  always #5 CLK = ~CLK;

  data_cache dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE),
    .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(READDATA), .BUSYWAIT(BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
`ifdef DATA_CACHE_STATS_EN
    , .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;
  int lat      = 5;

  // ---------------- main memory model ----------------
  logic [31:0] init_blk [64];
  logic [31:0] mem_blk  [64];
  logic        mem_load = 1'b1;
  int          mem_cnt;
  logic        mem_req;
  logic        log_wr   [256];
  logic [5:0]  log_addr [256];
  logic [31:0] log_data [256];
  int          log_n;

  assign mem_req      = MEM_READ | MEM_WRITE;
  assign MEM_BUSYWAIT = mem_req && (mem_cnt < lat - 1);
  assign MEM_READDATA = mem_blk[MEM_ADDRESS];

  always @(posedge CLK) begin
    if (mem_load) begin
      for (int i = 0; i < 64; i++) mem_blk[i] <= init_blk[i];
      mem_cnt <= 0;
      log_n   <= 0;
    end else if (!mem_req) begin
      mem_cnt <= 0;
    end else if (!MEM_BUSYWAIT) begin
      mem_cnt <= 0;
      if (MEM_WRITE) mem_blk[MEM_ADDRESS] <= MEM_WRITEDATA;
      log_wr[log_n % 256]   <= MEM_WRITE;
      log_addr[log_n % 256] <= MEM_ADDRESS;
      log_data[log_n % 256] <= MEM_WRITEDATA;
      log_n <= log_n + 1;
    end else begin
      mem_cnt <= mem_cnt + 1;
    end
  end

  // ---------------- reference model ----------------
  // ref_bytes: the value a load must return (CPU-visible memory image).
  // ln_*: which block each line currently holds and whether it was stored to.
  logic [7:0] ref_bytes [256];
  logic       ln_valid  [8];
  logic [2:0] ln_tag    [8];
  logic       ln_dirty  [8];

  task automatic sync_ref();
    for (int a = 0; a < 256; a++) ref_bytes[a] = mem_blk[a / 4][(a % 4) * 8 +: 8];
    for (int i = 0; i < 8; i++) begin
      ln_valid[i] = 1'b0;
      ln_dirty[i] = 1'b0;
      ln_tag[i]   = 3'd0;
    end
  endtask

  function automatic int predict_stall(input logic [7:0] addr);
    int idx = int'(addr[4:2]);
    if (ln_valid[idx] && ln_tag[idx] == addr[7:5]) return 0;
    if (ln_valid[idx] && ln_dirty[idx]) return 2 * lat + 2;
    return lat + 2;
  endfunction

  task automatic model_commit(input logic wr, input logic [7:0] addr, input logic [7:0] wd);
    int idx = int'(addr[4:2]);
    if (!(ln_valid[idx] && ln_tag[idx] == addr[7:5])) begin
      ln_valid[idx] = 1'b1;
      ln_tag[idx]   = addr[7:5];
      ln_dirty[idx] = 1'b0;
    end
    if (wr) begin
      ref_bytes[addr] = wd;
      ln_dirty[idx]   = 1'b1;
    end
  endtask

  // Drive one CPU access, wait out BUSYWAIT (bounded), return load data and stall cycles.
  task automatic access(input logic rd, input logic wr, input logic [7:0] addr,
                        input logic [7:0] wd, output logic [7:0] rdata, output int stall);
    @(negedge CLK);
    READ = rd; WRITE = wr; ADDRESS = addr; WRITEDATA = wd;
    #1;
    stall = 0;
    while (BUSYWAIT && stall < 200) begin
      @(posedge CLK);
      @(negedge CLK);
      #1;
      stall++;
    end
    if (BUSYWAIT) begin
      n_checks++;
      $display("FAIL access_timeout addr=%02h busywait still high after %0d cycles", addr, stall);
    end
    rdata = READDATA;
    @(posedge CLK);
    #1;
    READ = 1'b0; WRITE = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    RESET = 1'b1; READ = 1'b0; WRITE = 1'b0; ADDRESS = 8'hFF; WRITEDATA = 8'h00;
    mem_load = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    mem_load = 1'b0;
    n_checks++; if (MEM_READ !== 1'b0) $display("FAIL reset_mem_read got=%b exp=0", MEM_READ); else n_pass++;
    n_checks++; if (MEM_WRITE !== 1'b0) $display("FAIL reset_mem_write got=%b exp=0", MEM_WRITE); else n_pass++;
    n_checks++; if (BUSYWAIT !== 1'b0) $display("FAIL reset_busywait got=%b exp=0", BUSYWAIT); else n_pass++;
    n_checks++; if (READDATA !== 8'h00) $display("FAIL reset_readdata got=%02h exp=00", READDATA); else n_pass++;
    RESET = 1'b0;
    sync_ref();
  endtask

  task automatic test_cold_miss();
    logic [7:0] rd; int st; int base = log_n;
    access(1'b1, 1'b0, 8'h04, 8'h00, rd, st);
    model_commit(1'b0, 8'h04, 8'h00);
    n_checks++; if (st !== lat + 2) $display("FAIL cold_stall got=%0d exp=%0d", st, lat + 2); else n_pass++;
    n_checks++; if (rd !== 8'hAA) $display("FAIL cold_readdata got=%02h exp=aa", rd); else n_pass++;
    n_checks++; if (log_n !== base + 1) $display("FAIL cold_mem_txns got=%0d exp=%0d", log_n - base, 1); else n_pass++;
    n_checks++; if (log_wr[base % 256] !== 1'b0 || log_addr[base % 256] !== 6'h01)
      $display("FAIL cold_mem_req got=wr%b/%02h exp=wr0/01", log_wr[base % 256], log_addr[base % 256]); else n_pass++;
  endtask

  task automatic test_write_hit();
    logic [7:0] rd; int st;
    access(1'b0, 1'b1, 8'h05, 8'h5A, rd, st);
    model_commit(1'b1, 8'h05, 8'h5A);
    n_checks++; if (st !== 0) $display("FAIL write_hit_stall got=%0d exp=0", st); else n_pass++;
    access(1'b1, 1'b0, 8'h05, 8'h00, rd, st);
    n_checks++; if (rd !== 8'h5A || st !== 0) $display("FAIL write_hit_readback got=%02h/%0d exp=5a/0", rd, st); else n_pass++;
  endtask

  task automatic test_dirty_evict();
    logic [7:0] rd; logic [7:0] exp_rd; int st; int base = log_n;
    exp_rd = ref_bytes[8'h24];
    access(1'b1, 1'b0, 8'h24, 8'h00, rd, st);
    model_commit(1'b0, 8'h24, 8'h00);
    n_checks++; if (st !== 2 * lat + 2) $display("FAIL evict_stall got=%0d exp=%0d", st, 2 * lat + 2); else n_pass++;
    n_checks++; if (log_n !== base + 2) $display("FAIL evict_mem_txns got=%0d exp=2", log_n - base); else n_pass++;
    n_checks++; if (log_wr[base % 256] !== 1'b1 || log_addr[base % 256] !== 6'h01 || log_data[base % 256] !== 32'hDDCC5AAA)
      $display("FAIL evict_writeback got=wr%b/%02h/%08h exp=wr1/01/ddcc5aaa",
               log_wr[base % 256], log_addr[base % 256], log_data[base % 256]); else n_pass++;
    n_checks++; if (log_wr[(base + 1) % 256] !== 1'b0 || log_addr[(base + 1) % 256] !== 6'h09)
      $display("FAIL evict_refill got=wr%b/%02h exp=wr0/09", log_wr[(base + 1) % 256], log_addr[(base + 1) % 256]); else n_pass++;
    n_checks++; if (rd !== exp_rd) $display("FAIL evict_readdata got=%02h exp=%02h", rd, exp_rd); else n_pass++;
  endtask

  task automatic test_read_write_both();
    logic [7:0] rd; int st;
    access(1'b1, 1'b1, 8'h10, 8'h77, rd, st);
    model_commit(1'b1, 8'h10, 8'h77);
    access(1'b1, 1'b0, 8'h10, 8'h00, rd, st);
    n_checks++; if (rd !== 8'h77 || st !== 0) $display("FAIL rw_both got=%02h/%0d exp=77/0", rd, st); else n_pass++;
  endtask

  task automatic test_index_wrap();
    logic [7:0] rd; logic [7:0] exp_rd; int st; int base = log_n;
    exp_rd = ref_bytes[8'hFF];
    access(1'b1, 1'b0, 8'hFF, 8'h00, rd, st);
    model_commit(1'b0, 8'hFF, 8'h00);
    n_checks++; if (rd !== exp_rd || log_addr[base % 256] !== 6'h3F)
      $display("FAIL index_wrap got=%02h/%02h exp=%02h/3f", rd, log_addr[base % 256], exp_rd); else n_pass++;
  endtask

  task automatic test_reset_mid_miss();
    logic [7:0] rd; logic [7:0] exp_rd; int st; int base;
    @(negedge CLK);
    READ = 1'b1; ADDRESS = 8'h04;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    n_checks++; if (MEM_READ !== 1'b1) $display("FAIL midmiss_pending got=%b exp=1", MEM_READ); else n_pass++;
    base = log_n;
    RESET = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    n_checks++; if (MEM_READ !== 1'b0 || MEM_WRITE !== 1'b0)
      $display("FAIL midmiss_abort got=%b%b exp=00", MEM_READ, MEM_WRITE); else n_pass++;
    n_checks++; if (log_n !== base) $display("FAIL midmiss_no_txn got=%0d exp=0", log_n - base); else n_pass++;
    RESET = 1'b0; READ = 1'b0;
    sync_ref();
    exp_rd = ref_bytes[8'h04];
    access(1'b1, 1'b0, 8'h04, 8'h00, rd, st);
    model_commit(1'b0, 8'h04, 8'h00);
    n_checks++; if (st !== lat + 2 || rd !== exp_rd)
      $display("FAIL post_reset_miss got=%0d/%02h exp=%0d/%02h", st, rd, lat + 2, exp_rd); else n_pass++;
    exp_rd = ref_bytes[8'h10];
    access(1'b1, 1'b0, 8'h10, 8'h00, rd, st);
    model_commit(1'b0, 8'h10, 8'h00);
    n_checks++; if (st !== lat + 2 || rd !== exp_rd)
      $display("FAIL post_reset_dirty_lost got=%0d/%02h exp=%0d/%02h", st, rd, lat + 2, exp_rd); else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] rd; logic [7:0] addr; logic [7:0] wd; logic [7:0] exp_rd;
    logic [2:0] tg; logic [2:0] idx; logic [1:0] off;
    int st; int exp_st; int kind;
    lat = int'($urandom_range(1, 4));
    for (int n = 0; n < 150; n++) begin
      tg = 3'($urandom_range(0, 2)); idx = 3'($urandom_range(0, 7)); off = 2'($urandom_range(0, 3));
      addr = {tg, idx, off};
      wd = 8'($urandom);
      kind = int'($urandom_range(0, 2));
      exp_st = predict_stall(addr);
      exp_rd = ref_bytes[addr];
      access(kind != 1, kind != 0, addr, wd, rd, st);
      model_commit(kind != 0, addr, wd);
      n_checks++; if (st !== exp_st) $display("FAIL rand_stall n=%0d addr=%02h got=%0d exp=%0d", n, addr, st, exp_st); else n_pass++;
      if (kind == 0) begin
        n_checks++; if (rd !== exp_rd) $display("FAIL rand_read n=%0d addr=%02h got=%02h exp=%02h", n, addr, rd, exp_rd); else n_pass++;
      end
    end
    lat = 5;
  endtask

`ifdef DATA_CACHE_STATS_EN
  task automatic test_stats();
    logic [7:0] rd; int st;
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    n_checks++; if (HIT_COUNT !== 16'h0000 || MISS_COUNT !== 16'h0000)
      $display("FAIL stats_reset got=%04h/%04h exp=0000/0000", HIT_COUNT, MISS_COUNT); else n_pass++;
    RESET = 1'b0;
    sync_ref();
    // The miss access finishes with an IDLE hit, so it contributes one hit too.
    access(1'b1, 1'b0, 8'h04, 8'h00, rd, st);
    access(1'b1, 1'b0, 8'h05, 8'h00, rd, st);
    access(1'b1, 1'b0, 8'h06, 8'h00, rd, st);
    @(negedge CLK);
    n_checks++; if (HIT_COUNT !== 16'd3 || MISS_COUNT !== 16'd1)
      $display("FAIL stats_counts got=%0d/%0d exp=3/1", HIT_COUNT, MISS_COUNT); else n_pass++;
    READ = 1'b1; ADDRESS = 8'h05;
    repeat (65536) @(posedge CLK);
    @(negedge CLK);
    READ = 1'b0;
    n_checks++; if (HIT_COUNT !== 16'hFFFF || MISS_COUNT !== 16'd1)
      $display("FAIL stats_saturate got=%04h/%0d exp=ffff/1", HIT_COUNT, MISS_COUNT); else n_pass++;
  endtask
`endif

  initial begin
    for (int i = 0; i < 64; i++) init_blk[i] = $urandom;
    init_blk[1] = 32'hDDCCBBAA;
    test_reset();
    test_cold_miss();
    test_write_hit();
    test_dirty_evict();
    test_read_write_both();
    test_index_wrap();
    test_reset_mid_miss();
    test_random();
`ifdef DATA_CACHE_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
